// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side stream adapter.
// The optional counters in fifo_rd_stream are enabled by FIFO_RD_STREAM_STATS_EN.
package fifo_rd_pkg;

  // Largest buffer depth cnt_t can count up to (0..MAX_BUF_DEPTH inclusive).
  localparam int MAX_BUF_DEPTH = 256;
  localparam int CNT_W         = $clog2(MAX_BUF_DEPTH + 1);
  localparam int STATS_W       = 32;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [STATS_W-1:0] stats_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// Circular prefetch buffer: captures FIFO read data at the tail, presents the
// oldest word at the head from a register.
module rd_prefetch_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output cnt_t             count_o,
  output logic [WIDTH-1:0] head_data_o
);

  localparam int PTR_W = ptr_w(BUF_DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t LAST_PTR = ptr_t'(BUF_DEPTH - 1);

  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  cnt_t             count_q, count_d;
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + ptr_t'(1);
    end
    if (pop_i) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + ptr_t'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read FIFO into a valid/ready stream, hiding the read latency.
// Define FIFO_RD_STREAM_STATS_EN to add the xfer_cnt/stall_cnt outputs.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rd_en,
  input  logic [WIDTH-1:0]   rdata,
  input  logic               empty_flag,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STATS_W-1:0] xfer_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);

  cnt_t count;
  cnt_t occupancy;
  logic pop;
  logic inflight_q, inflight_d;

  assign pop       = out_valid && out_ready;
  assign occupancy = count + cnt_t'(inflight_q);

  // Credit (BUF_DEPTH - occupancy + pop) is positive exactly when there is a
  // free slot now, or a full buffer is being popped this cycle.
  assign rd_en      = rst && !empty_flag && ((occupancy < cnt_t'(BUF_DEPTH)) || pop);
  assign inflight_d = rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  rd_prefetch_buf #(
    .WIDTH    (WIDTH),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (inflight_q),
    .push_data_i(rdata),
    .pop_i      (pop),
    .count_o    (count),
    .head_data_o(out_data)
  );

  assign out_valid = (count != '0);

  always @(posedge clk) begin
    if (rst) begin
      assert (occupancy <= cnt_t'(BUF_DEPTH));
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  stats_t xfer_cnt_q, xfer_cnt_d;
  stats_t stall_cnt_q, stall_cnt_d;

  // Transfers wrap; stalls saturate so a long-blocked consumer stays visible.
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q + stats_t'(1);
    end
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + stats_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural registered-read FIFO
// and an in-order scoreboard on every stream pop.
module tb_fifo_rd_stream;

  localparam int WIDTH     = 32;
  localparam int BUF_DEPTH = 2;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             rd_en;
  logic [WIDTH-1:0] rdata      = '0;
  logic             empty_flag = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready  = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int occModel = 0;

  logic [WIDTH-1:0] fifoQ[$];
  logic [WIDTH-1:0] pushQ[$];
  logic [WIDTH-1:0] expectQ[$];

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .WIDTH    (WIDTH),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .empty_flag(empty_flag),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] word);
    pushQ.push_back(word);
    expectQ.push_back(word);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered-read FIFO: data appears the cycle after rd_en, writes land on the edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifoQ.delete();
      pushQ.delete();
      rdata      <= '0;
      empty_flag <= 1'b1;
    end else begin
      if (rd_en && (fifoQ.size() > 0)) begin
        rdata <= fifoQ.pop_front();
      end
      while (pushQ.size() > 0) begin
        fifoQ.push_back(pushQ.pop_front());
      end
      empty_flag <= (fifoQ.size() == 0);
    end
  end

  // Mid-cycle monitor: ordering, no read of an empty FIFO, bounded occupancy.
  always @(negedge clk) begin
    logic [WIDTH-1:0] expWord;
    if (!rst) begin
      occModel = 0;
    end else begin
      checkOutput("rdWhileEmpty", {31'b0, rd_en && empty_flag}, 32'd0);
      if (out_valid && out_ready) begin
        expWord = (expectQ.size() > 0) ? expectQ.pop_front() : 'x;
        checkOutput("scoreboardOrder", out_data, expWord);
      end
      occModel = occModel + int'(rd_en) - int'(out_valid && out_ready);
      checkOutput("occupancyBound", {31'b0, occModel <= BUF_DEPTH}, 32'd1);
    end
  end

  initial begin
    int stallReads;

    #2 rst = 1'b0;
    tick();
    tick();
    checkOutput("resetRdEn", {31'b0, rd_en}, 32'd0);
    checkOutput("resetValid", {31'b0, out_valid}, 32'd0);
    checkOutput("resetData", out_data, 32'd0);
    rst = 1'b1;

    $display("[TB] idle with empty FIFO");
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idleRdEn", {31'b0, rd_en}, 32'd0);
      checkOutput("idleValid", {31'b0, out_valid}, 32'd0);
      checkOutput("idleData", out_data, 32'd0);
    end

    $display("[TB] three-word preload, consumer ready");
    out_ready = 1'b1;
    applyStimulus(32'h11);
    applyStimulus(32'h22);
    applyStimulus(32'h33);
    tick();
    checkOutput("preRdEnN", {31'b0, rd_en}, 32'd1);
    checkOutput("preValidN", {31'b0, out_valid}, 32'd0);
    tick();
    checkOutput("preValidN1", {31'b0, out_valid}, 32'd0);
    tick();
    checkOutput("preValidN2", {31'b0, out_valid}, 32'd1);
    checkOutput("preData0", out_data, 32'h11);
    tick();
    checkOutput("preData1", out_data, 32'h22);
    tick();
    checkOutput("preData2", out_data, 32'h33);
    checkOutput("preRdEnDone", {31'b0, rd_en}, 32'd0);
    tick();
    checkOutput("preValidEnd", {31'b0, out_valid}, 32'd0);

    $display("[TB] sixteen-word stream at full rate");
    for (int i = 0; i < 16; i++) applyStimulus(32'h100 + i);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      checkOutput("streamValid", {31'b0, out_valid}, 32'd1);
      checkOutput("streamData", out_data, 32'h100 + i);
      tick();
    end
    checkOutput("streamValidEnd", {31'b0, out_valid}, 32'd0);

    $display("[TB] back-pressure stall");
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(32'h200 + i);
    stallReads = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      stallReads += int'(rd_en);
    end
    checkOutput("stallReadCount", stallReads, BUF_DEPTH);
    checkOutput("stallValid", {31'b0, out_valid}, 32'd1);
    checkOutput("stallHeadData", out_data, 32'h200);
`ifdef FIFO_RD_STREAM_STATS_EN
    checkOutput("stallCnt", stall_cnt, 32'd3);
    checkOutput("xferCntBefore", xfer_cnt, 32'd19);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("drainValid", {31'b0, out_valid}, 32'd1);
      checkOutput("drainData", out_data, 32'h200 + i);
      tick();
    end
    checkOutput("drainValidEnd", {31'b0, out_valid}, 32'd0);

    $display("[TB] toggling ready with random fill");
    for (int i = 0; i < 60; i++) begin
      out_ready = i[0];
      if ($urandom_range(0, 2) == 0) applyStimulus($urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; (i < 200) && (expectQ.size() > 0); i++) tick();
    checkOutput("randomDrained", expectQ.size(), 32'd0);
    tick();
    checkOutput("randomValidEnd", {31'b0, out_valid}, 32'd0);

    $display("[TB] reset with a full buffer");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(32'h300 + i);
    repeat (4) tick();
    checkOutput("fullValid", {31'b0, out_valid}, 32'd1);
    checkOutput("fullData", out_data, 32'h300);
    rst = 1'b0;
    #1;
    checkOutput("midRstValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midRstRdEn", {31'b0, rd_en}, 32'd0);
    checkOutput("midRstData", out_data, 32'd0);
    expectQ.delete();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("postRstValid", {31'b0, out_valid}, 32'd0);
    checkOutput("postRstRdEn", {31'b0, rd_en}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    checkOutput("postRstXfer", xfer_cnt, 32'd0);
    checkOutput("postRstStall", stall_cnt, 32'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(32'h400 + i);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("postRstData", out_data, 32'h400 + i);
      tick();
    end
    checkOutput("postRstValidEnd", {31'b0, out_valid}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    checkOutput("postRstXfer5", xfer_cnt, 32'd5);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
